io_bus_responder: RTL and testbench
===================================

// Module: io_bus_responder
// PURPOSE
//  Memory-mapped I/O peripheral; bus responder for the CPU's 16-bit address bus and
//  shared 16-bit inout data bus. Decodes an 8-word window, answers reads by driving the
//  data bus in the same cycle, and latches writes on the clock edge. Holds an RX FIFO fed
//  by an external producer, an output latch and a reload down-counter timer. Drives the
//  CPU's 8-bit interrupt input vector (int_e).
// PARAMETERS
//  BASE_ADDR  16'hFF00  word address of register 0; the window is BASE_ADDR..BASE_ADDR+7
//  DEPTH      4         RX FIFO entries; power of 2, >=2
// PORTS
//  clk          in     1   single clock; every register updates on the rising edge
//  reset        in     1   synchronous, active-high
//  direcciones  in     16  CPU address
//  datos        inout  16  shared data bus; driven only during a selected read, else 16'bz
//  rd           in     1   CPU read strobe, valid for the whole cycle
//  wr           in     1   CPU write strobe; write data is sampled from datos at the edge
//  rx_valid     in     1   producer offers rx_data
//  rx_data      in     16  producer data
//  rx_ready     out    1   FIFO can accept; equals !full
//  out_port     out    16  output latch
//  int_e        out    8   interrupt lines to the CPU: [0] timer pending, [1] RX non-empty,
//                          [2] overflow sticky, [7:3] tied to 0
// BEHAVIOUR
//  sel = (direcciones[15:3] == BASE_ADDR[15:3]); off = direcciones[2:0].
//  rd and wr asserted together: wr takes effect and the bus is not driven (bus error;
//  test it, but software must not do it).
//  Register map (R = read, W = write):
//   0 R  RX_DATA: head of the FIFO; 16'h0000 when empty. The pop occurs at the edge that
//        ends the read cycle, only if the FIFO is non-empty.
//   1 R  STATUS: {11'b0, tmr_en, ovf, tpend, full, empty}
//   2 RW OUT: out_port <= datos on write; a read returns out_port
//   3 RW RELOAD: reload <= datos on write; a read returns reload
//   4 R  COUNT: current timer count
//   4 W  CTRL: bit0 -> tmr_en; bit1 = 1 clears tpend; bit2 = 1 clears ovf; bit3 = 1 loads
//        count <= reload
//   5-7  read 16'h0000; writes are ignored
//  Read path is combinational: datos = rd && sel && !wr ? rdata : 16'bz. Zero latency
//  (single-cycle CPU).
//  RX FIFO: circular, with read and write pointers of log2(DEPTH)+1 bits.
//   - push when rx_valid && !full
//   - rx_valid && full: the word is dropped and ovf <= 1
//   - a push and a pop in the same edge when full: the pop frees a slot, but rx_ready was
//     0 that cycle, so the push is dropped and ovf is set
//   - a push and a pop in the same edge when empty: the pop is suppressed (RX_DATA read
//     0) and the push succeeds
//  Timer, when tmr_en = 1, per cycle:
//   - count == 0: count <= reload and tpend <= 1
//   - otherwise count <= count - 1
//   - reload == 0: tpend is set every cycle
//   - a CTRL write with bit3 takes priority over the decrement in that cycle
//   - a clear of tpend in the same cycle that the timer sets it: set wins
//  tmr_en = 0: count holds.
//  Reset values: out_port = 0, reload = 0, count = 0, tmr_en = 0, tpend = 0, ovf = 0,
//  FIFO empty (pointers 0), rx_ready = 1, int_e = 0, datos released (z). A reset in the
//  middle of a read or a push overrides everything; nothing is stored.
// TESTING
//  1 reset; read STATUS at FF01 -> 16'h0001; int_e = 0; datos z with rd = 0.
//  2 write 16'hABCD to FF02 -> out_port = ABCD the next cycle; read FF02 -> ABCD.
//  3 push 1,2,3,4 (DEPTH = 4) -> rx_ready = 0, STATUS = 0002; push 5 -> ovf = 1,
//    int_e[2] = 1; four reads of FF00 -> 1,2,3,4; a fifth read -> 0000, int_e[1] = 0.
//  4 RELOAD = 3, CTRL = 16'h0009 -> tpend rises on the 4th cycle after enable; repeats
//    every 4 cycles; CTRL = 0003 clears it.
//  5 with the FIFO full, a pop and rx_valid in the same cycle -> the word is dropped and
//    ovf is set; with the FIFO empty, a read and a push in the same cycle -> count = 1.
//  6 assert reset during an active timer and a full FIFO -> every reset value above holds
//    on the next cycle.

Source files
------------

// File: rtl/io_bus_responder.sv
// io_bus_responder: memory-mapped I/O responder on the CPU's 16-bit bus.
// It decodes an 8-word window, answers reads combinationally on the shared data bus,
// and latches writes at the clock edge. It holds an RX FIFO, an output latch and a
// reload down-counter timer, and it drives the CPU's interrupt vector.
module io_bus_responder #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] direcciones,
    inout  wire  [15:0] datos,
    input  logic        rd,
    input  logic        wr,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready,
    output logic [15:0] out_port,
    output logic [7:0]  int_e
);

    localparam int AW = $clog2(DEPTH);

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]  mem_q [DEPTH];
    logic [15:0]  out_q, out_d, reload_q, reload_d, count_q, count_d;
    logic         tmr_en_q, tmr_en_d, tpend_q, tpend_d, ovf_q, ovf_d;

    logic         sel, wr_sel, rd_sel, ctrl_wr;
    logic [2:0]   off;
    logic         empty, full, push, pop, fire;
    logic [15:0]  rdata;

    assign sel     = (direcciones[15:3] == BASE_ADDR[15:3]);
    assign off     = direcciones[2:0];
    assign wr_sel  = wr && sel;
    // A write wins over a simultaneous read, so a read is only serviced without wr.
    assign rd_sel  = rd && sel && !wr;
    assign ctrl_wr = wr_sel && (off == 3'd4);

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // The push decision uses the pre-edge full flag, so a pop in the same cycle cannot
    // make room for the word that was offered.
    assign push  = rx_valid && !full;
    assign pop   = rd_sel && (off == 3'd0) && !empty;
    assign fire  = tmr_en_q && (count_q == 16'd0);

    assign rx_ready = !full;
    assign out_port = out_q;
    assign int_e    = {5'b0, ovf_q, !empty, tpend_q};

    // Read mux: the selected register is placed on the bus in the same cycle.
    always_comb begin
        rdata = 16'h0000;
        case (off)
            3'd0:    rdata = empty ? 16'h0000 : mem_q[rptr_q[AW-1:0]];
            3'd1:    rdata = {11'b0, tmr_en_q, ovf_q, tpend_q, full, empty};
            3'd2:    rdata = out_q;
            3'd3:    rdata = reload_q;
            3'd4:    rdata = count_q;
            default: rdata = 16'h0000;
        endcase
    end

    assign datos = rd_sel ? rdata : 16'bz;

    // Next state for the FIFO pointers, the registers and the timer.
    always_comb begin
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
        out_d    = (wr_sel && off == 3'd2) ? datos : out_q;
        reload_d = (wr_sel && off == 3'd3) ? datos : reload_q;
        tmr_en_d = ctrl_wr ? datos[0] : tmr_en_q;

        ovf_d = ovf_q;
        if (ctrl_wr && datos[2]) ovf_d = 1'b0;
        if (rx_valid && full)    ovf_d = 1'b1;

        count_d = count_q;
        if (tmr_en_q) count_d = (count_q == 16'd0) ? reload_q : count_q - 16'd1;
        if (ctrl_wr && datos[3]) count_d = reload_q;

        // When software clears tpend in the same cycle that the timer fires, the fire wins.
        tpend_d = tpend_q;
        if (ctrl_wr && datos[1]) tpend_d = 1'b0;
        if (fire)                tpend_d = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            out_q    <= 16'h0000;
            reload_q <= 16'h0000;
            count_q  <= 16'h0000;
            tmr_en_q <= 1'b0;
            tpend_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            tmr_en_q <= tmr_en_d;
            tpend_q  <= tpend_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; only the pointers need a reset.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wptr_q[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed scenarios followed by randomized bus and producer
// traffic, all checked against a queue-based reference model of the register map.
module tb_io_bus_responder;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] direcciones = 16'h0000;
    logic        rd = 1'b0, wr = 1'b0, rx_valid = 1'b0;
    logic [15:0] rx_data = 16'h0000;
    logic        rx_ready;
    logic [15:0] out_port;
    logic [7:0]  int_e;
    logic [15:0] drv = 16'h0000;
    logic        drv_en = 1'b0;
    wire  [15:0] datos;

    assign datos = drv_en ? drv : 16'bz;

    io_bus_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .direcciones(direcciones), .datos(datos),
        .rd(rd), .wr(wr), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .out_port(out_port), .int_e(int_e)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a plain queue and the timer is plain integers.
    logic [15:0] q[$];
    int unsigned m_out, m_rel, m_cnt;
    bit m_en, m_tp, m_ovf, m_valid;
    logic [15:0] last_rd;

    function automatic logic [15:0] m_rdata(input int o);
        case (o)
            0: return (q.size() > 0) ? q[0] : 16'h0000;
            1: return {11'b0, m_en, m_ovf, m_tp, q.size() == DEPTH, q.size() == 0};
            2: return 16'(m_out);
            3: return 16'(m_rel);
            4: return 16'(m_cnt);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_edge(input logic [15:0] a, input logic r, input logic w,
                          input logic [15:0] d, input logic rv, input logic [15:0] rxd,
                          input logic rst);
        bit s, full, empty, ctl, fires;
        int o;
        if (rst) begin
            q.delete();
            m_out = 0; m_rel = 0; m_cnt = 0; m_en = 0; m_tp = 0; m_ovf = 0;
            return;
        end
        s     = (a >= BASE) && (a <= BASE + 16'd7);
        o     = int'(a - BASE);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        ctl   = w && s && o == 4;
        fires = m_en && m_cnt == 0;
        if (ctl && d[2]) m_ovf = 0;
        if (rv && full)  m_ovf = 1;
        if (r && !w && s && o == 0 && !empty) void'(q.pop_front());
        if (rv && !full) q.push_back(rxd);
        if (ctl && d[1]) m_tp = 0;
        if (fires)       m_tp = 1;
        if (m_en) m_cnt = (m_cnt == 0) ? m_rel : m_cnt - 1;
        if (ctl && d[3]) m_cnt = m_rel;
        if (ctl) m_en = d[0];
        if (w && s && o == 2) m_out = d;
        if (w && s && o == 3) m_rel = d;
    endtask

    // One bus cycle: drive, check combinational outputs mid-cycle, then step the model.
    task automatic step(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d,
                        input logic rv, input logic [15:0] rxd, input logic rst);
        bit s;
        direcciones = a; rd = r; wr = w; drv = d; drv_en = w;
        rx_valid = rv; rx_data = rxd; reset = rst;
        @(negedge clk);
        last_rd = datos;
        s = (a >= BASE) && (a <= BASE + 16'd7);
        if (m_valid) begin
            if (r && !w && s) chk("rdata", datos, m_rdata(int'(a - BASE)));
            if (w) chk("bus_wr", datos, d);
            chk("rx_ready", {15'b0, rx_ready}, {15'b0, q.size() != DEPTH});
            chk("int_e", {8'b0, int_e}, {8'b0, 5'b0, m_ovf, q.size() != 0, m_tp});
            chk("out_port", out_port, 16'(m_out));
        end
        @(posedge clk);
        m_edge(a, r, w, d, rv, rxd, rst);
        if (rst) m_valid = 1;
        #1;
    endtask

    task automatic idle();                          step(16'h0000, 0, 0, 0, 0, 0, 0); endtask
    task automatic rdw(input int o);                step(BASE + 16'(o), 1, 0, 0, 0, 0, 0); endtask
    task automatic wrw(input int o, input logic [15:0] d); step(BASE + 16'(o), 0, 1, d, 0, 0, 0); endtask
    task automatic pushw(input logic [15:0] d);     step(16'h0000, 0, 0, 0, 1, d, 0); endtask

    initial begin
        // 1: reset state
        step(16'h0000, 0, 0, 0, 0, 0, 1);
        chk("t1_int_e", {8'b0, int_e}, 16'h0000);
        rdw(1); chk("t1_status", last_rd, 16'h0001);

        // 2: output latch
        wrw(2, 16'hABCD);
        chk("t2_out", out_port, 16'hABCD);
        rdw(2); chk("t2_rd_out", last_rd, 16'hABCD);

        // 3: fill, overflow, drain, underflow read
        for (int i = 1; i <= 4; i++) pushw(16'(i));
        chk("t3_ready", {15'b0, rx_ready}, 16'h0000);
        rdw(1); chk("t3_status", last_rd, 16'h0002);
        pushw(16'd5);
        chk("t3_ovf", {8'b0, int_e}, 16'h0006);
        for (int i = 1; i <= 4; i++) begin
            rdw(0); chk("t3_pop", last_rd, 16'(i));
        end
        rdw(0); chk("t3_empty_rd", last_rd, 16'h0000);
        chk("t3_int_e", {8'b0, int_e}, 16'h0004);
        wrw(4, 16'h0004);
        chk("t3_ovf_clr", {8'b0, int_e}, 16'h0000);

        // 4: timer period and clear
        wrw(3, 16'd3);
        wrw(4, 16'h0009);
        for (int i = 0; i < 3; i++) begin
            idle(); chk("t4_tp_low", {15'b0, int_e[0]}, 16'h0000);
        end
        idle(); chk("t4_tp_rise", {15'b0, int_e[0]}, 16'h0001);
        wrw(4, 16'h0003); chk("t4_tp_clr", {15'b0, int_e[0]}, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            idle(); chk("t4_tp_low2", {15'b0, int_e[0]}, 16'h0000);
        end
        idle(); chk("t4_tp_again", {15'b0, int_e[0]}, 16'h0001);
        wrw(4, 16'h0002);

        // 5: simultaneous pop and push at full and at empty
        for (int i = 0; i < 4; i++) pushw(16'h10 + 16'(i));
        step(BASE, 1, 0, 0, 1, 16'h0099, 0);
        chk("t5_full_pop", last_rd, 16'h0010);
        rdw(1); chk("t5_full_status", last_rd, 16'h0008);
        for (int i = 1; i <= 3; i++) begin
            rdw(0); chk("t5_drain", last_rd, 16'h10 + 16'(i));
        end
        wrw(4, 16'h0004);
        step(BASE, 1, 0, 0, 1, 16'h0055, 0);
        chk("t5_empty_rd", last_rd, 16'h0000);
        rdw(1); chk("t5_one_entry", last_rd, 16'h0000);
        rdw(0); chk("t5_rd55", last_rd, 16'h0055);

        // bus error: rd and wr together, the write lands and only the bench drives
        step(BASE + 16'd2, 1, 1, 16'h1234, 0, 0, 0);
        chk("berr_bus", last_rd, 16'h1234);
        chk("berr_out", out_port, 16'h1234);

        // 6: reset during active timer, full FIFO, read and push
        wrw(3, 16'd5); wrw(4, 16'h0009);
        for (int i = 0; i < 5; i++) pushw(16'h20 + 16'(i));
        step(BASE, 1, 0, 0, 1, 16'h0077, 1);
        chk("t6_out", out_port, 16'h0000);
        chk("t6_ready", {15'b0, rx_ready}, 16'h0001);
        chk("t6_int_e", {8'b0, int_e}, 16'h0000);
        rdw(1); chk("t6_status", last_rd, 16'h0001);
        rdw(3); chk("t6_reload", last_rd, 16'h0000);
        rdw(4); chk("t6_count", last_rd, 16'h0000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a, d;
            logic r, w, rv, rst;
            int op;
            a  = ($urandom_range(0, 9) < 8) ? BASE + 16'($urandom_range(0, 7)) : 16'($urandom);
            op = $urandom_range(0, 9);
            r  = (op <= 3) || (op == 6);
            w  = (op == 4) || (op == 5) || (op == 6);
            d  = 16'($urandom);
            if (a == BASE + 16'd3 && $urandom_range(0, 3) != 0) d = 16'($urandom_range(0, 7));
            rv  = $urandom_range(0, 1) == 1;
            rst = $urandom_range(0, 199) == 0;
            step(a, r, w, d, rv, 16'($urandom), rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
